// File: rtl/link_tx.sv
// Flit-to-phit link transmitter with holding FIFO and Stop & Go flow control.
// Define LINK_TX_GO_REG_EN to register Go before it gates flit starts.
module link_tx #(
   parameter int FLIT_SIZE      = 64,
   parameter int PHIT_SIZE      = 16,
   parameter int FLIT_TYPE_SIZE = 2,
   parameter int QUEUE_SIZE     = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [FLIT_SIZE-1:0]      FlitIn,
   input  logic [FLIT_TYPE_SIZE-1:0] FlitTypeIn,
   input  logic                      BroadcastFlitIn,
   input  logic                      ValidIn,
   output logic                      Avail,
   output logic [PHIT_SIZE-1:0]      Flit,
   output logic [FLIT_TYPE_SIZE-1:0] FlitType,
   output logic                      BroadcastFlit,
   output logic                      Valid,
   input  logic                      Go,
   output logic                      Overflow
);

   localparam int NUM_PHITS = FLIT_SIZE / PHIT_SIZE;
   localparam int PW        = $clog2(NUM_PHITS) + 1;
   localparam int QW        = $clog2(QUEUE_SIZE);
   localparam int CW        = QW + 1;
   localparam logic [PW-1:0] LAST = PW'(NUM_PHITS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   logic [FLIT_SIZE-1:0]      mem_flit [QUEUE_SIZE];
   logic [FLIT_TYPE_SIZE-1:0] mem_type [QUEUE_SIZE];
   logic                      mem_bc   [QUEUE_SIZE];
   logic [QW-1:0]             wr_ptr, rd_ptr;
   logic [CW-1:0]             count_q;

   state_t                    state_q, state_d;
   logic [PW-1:0]             phit_q, phit_d;
   logic                      valid_q, valid_d;
   logic [PHIT_SIZE-1:0]      flit_q, flit_d;
   logic [FLIT_TYPE_SIZE-1:0] type_q, type_d;
   logic                      bc_q, bc_d;
   logic                      ovf_q;

   logic                      go_eff;
   logic                      wr, pop, empty;
   logic [FLIT_SIZE-1:0]      head;
   logic [PHIT_SIZE-1:0]      head_phit;

`ifdef LINK_TX_GO_REG_EN
   logic go_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) go_q <= 1'b0;
      else        go_q <= Go;
   end

   assign go_eff = go_q;
`else
   assign go_eff = Go;
`endif

   assign Avail     = count_q < CW'(QUEUE_SIZE);
   assign empty     = count_q == '0;
   assign wr        = ValidIn & Avail;
   assign head      = mem_flit[rd_ptr];
   assign head_phit = head[int'(phit_q) * PHIT_SIZE +: PHIT_SIZE];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QUEUE_SIZE; i++) begin
            mem_flit[i] <= '0;
            mem_type[i] <= '0;
            mem_bc[i]   <= 1'b0;
         end
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr) begin
            mem_flit[wr_ptr] <= FlitIn;
            mem_type[wr_ptr] <= FlitTypeIn;
            mem_bc[wr_ptr]   <= BroadcastFlitIn;
            wr_ptr           <= wr_ptr + QW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + QW'(1);
         unique case ({wr, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (ValidIn && !Avail) ovf_q <= 1'b1;
      end
   end

   // Go only gates flit starts; a started flit always runs to its last phit.
   always_comb begin
      state_d = state_q;
      phit_d  = phit_q;
      valid_d = 1'b0;
      flit_d  = flit_q;
      type_d  = type_q;
      bc_d    = bc_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && go_eff) begin
               valid_d = 1'b1;
               flit_d  = head[PHIT_SIZE-1:0];
               type_d  = mem_type[rd_ptr];
               bc_d    = mem_bc[rd_ptr];
               if (NUM_PHITS == 1) begin
                  pop = 1'b1;
               end else begin
                  state_d = SEND;
                  phit_d  = PW'(1);
               end
            end
         end
         SEND: begin
            valid_d = 1'b1;
            flit_d  = head_phit;
            type_d  = mem_type[rd_ptr];
            bc_d    = mem_bc[rd_ptr];
            if (phit_q == LAST) begin
               pop    = 1'b1;
               phit_d = '0;
               if (count_q > CW'(1) && go_eff) state_d = SEND;
               else                            state_d = IDLE;
            end else begin
               phit_d = phit_q + PW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         phit_q  <= '0;
         valid_q <= 1'b0;
         flit_q  <= '0;
         type_q  <= '0;
         bc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         phit_q  <= phit_d;
         valid_q <= valid_d;
         flit_q  <= flit_d;
         type_q  <= type_d;
         bc_q    <= bc_d;
      end
   end

   assign Flit          = flit_q;
   assign FlitType      = type_q;
   assign BroadcastFlit = bc_q;
   assign Valid         = valid_q;
   assign Overflow      = ovf_q;

endmodule
